pfd_tdc_5bit: RTL

Counter-based phase/frequency detector with time-to-digital conversion. Measures the time between rising edges of the reference and feedback clocks in `clk` cycles. Produces the sign-magnitude phase error (5-bit magnitude plus sign) that feeds the ADPLL's 5-bit sign-magnitude adder/subtractor and loop filter. It is the producer end of the sign-magnitude error path.

---
 rtl/adpll_pkg.sv | 35 +++
 rtl/pfd_tdc_5bit_if.sv | 17 +
 rtl/pfd_tdc_5bit_sync_edge_det.sv | 33 +++
 rtl/pfd_tdc_5bit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions for the sign-magnitude phase-error path.
// Holds error widths, the PFD state encoding, sign constants, the error
// payload struct and a helper that clips a raw count to the error range.
package adpll_pkg;

  localparam int unsigned ERR_W   = 5;
  localparam int unsigned ERR_MAX = 31;
  // One extra bit so a count of ERR_MAX+1 marks "clipped" without wrapping.
  localparam int unsigned CNT_W   = ERR_W + 1;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REF_FIRST = 2'd1,
    FB_FIRST  = 2'd2
  } pfd_state_t;

  typedef struct packed {
    logic [ERR_W-1:0] mag;
    logic             sign;
    logic             sat;
  } pfd_err_t;

  // Clip a raw elapsed count into a sign-magnitude error; zero is always positive.
  function automatic pfd_err_t make_err(input logic [CNT_W-1:0] cnt, input logic sign);
    pfd_err_t e;
    e.sat  = (cnt > CNT_W'(ERR_MAX));
    e.mag  = e.sat ? ERR_W'(ERR_MAX) : cnt[ERR_W-1:0];
    e.sign = (e.mag == '0) ? SIGN_POS : sign;
    return e;
  endfunction

endpackage

// File: rtl/pfd_tdc_5bit_if.sv
// Phase-error output bundle from the PFD/TDC to the sign-magnitude adder.
//   err_mag   : error magnitude in clk cycles (saturating at ERR_MAX)
//   err_sign  : 0 = ref leads, 1 = fb leads
//   err_valid : one-cycle strobe marking a new result
//   err_sat   : result was clipped or a cycle slip occurred
// master = producer (PFD), slave = consumer.
interface pfd_tdc_5bit_if;
  import adpll_pkg::*;

  logic [ERR_W-1:0] err_mag;
  logic             err_sign;
  logic             err_valid;
  logic             err_sat;

  modport master (output err_mag, output err_sign, output err_valid, output err_sat);
  modport slave  (input  err_mag, input  err_sign, input  err_valid, input  err_sat);
endinterface

// File: rtl/pfd_tdc_5bit_sync_edge_det.sv
// Synchronizer plus rising-edge detector for one asynchronous clock input.
//   clk, rst_n : sampling clock, async active-low reset
//   din        : asynchronous input
//   det        : registered one-cycle pulse, high STAGES cycles after the
//                first clk edge that samples din high
// All chain and previous-sample flops reset to 1, so an input that is
// already high when reset releases produces no edge.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic det
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain, previous sample and registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      det    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      det    <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/pfd_tdc_5bit.sv
// Counter-based phase/frequency detector with time-to-digital conversion.
// Measures the clk-cycle spacing between ref and fb rising edges and emits
// a sign-magnitude phase error strobe.
//   clk, rst_n     : sampling clock, async active-low reset
//   ref_in, fb_in  : reference and divided-DCO feedback clocks (async)
//   err (master)   : err_mag / err_sign / err_valid / err_sat, all registered
// Parameters: SYNC_STAGES (2..4) synchronizer depth; DEADZONE threshold.
// Optional feature: define PFD_DEADZONE_EN to report magnitudes
// <= DEADZONE as zero (suppresses bang-bang dither).
module pfd_tdc_5bit
  import adpll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEADZONE    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ref_in,
  input  logic                  fb_in,
  pfd_tdc_5bit_if.master        err
);

  logic             ref_det;
  logic             fb_det;
  pfd_state_t       state;
  pfd_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             rpt;
  pfd_err_t         rpt_raw;
  pfd_err_t         rpt_err;
  logic             unused_deadzone;

  assign unused_deadzone = |DEADZONE;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_ref_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ref_in),
    .det   (ref_det)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_fb_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fb_in),
    .det   (fb_det)
  );

  // Saturating increment; parks at ERR_MAX+1 so clipping stays visible.
  assign cnt_inc = (cnt == CNT_W'(ERR_MAX + 1)) ? cnt : cnt + CNT_W'(1);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, next count and the result to report this cycle.
  // A fresh start loads 1 so that cnt equals D2-D1 in the second-edge cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rpt       = 1'b0;
    rpt_raw   = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (ref_det && fb_det) begin
          rpt     = 1'b1;
          rpt_raw = make_err('0, SIGN_POS);
        end else if (ref_det) begin
          state_nxt = REF_FIRST;
          cnt_nxt   = CNT_W'(1);
        end else if (fb_det) begin
          state_nxt = FB_FIRST;
          cnt_nxt   = CNT_W'(1);
        end
      end
      REF_FIRST: begin
        if (fb_det) begin
          rpt     = 1'b1;
          rpt_raw = make_err(cnt, SIGN_POS);
          if (ref_det) begin
            cnt_nxt = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (ref_det) begin
          // Cycle slip: second ref edge before any fb edge.
          rpt     = 1'b1;
          rpt_raw = make_err(CNT_W'(ERR_MAX + 1), SIGN_POS);
          cnt_nxt = CNT_W'(1);
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      FB_FIRST: begin
        if (ref_det) begin
          rpt     = 1'b1;
          rpt_raw = make_err(cnt, SIGN_NEG);
          if (fb_det) begin
            cnt_nxt = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (fb_det) begin
          rpt     = 1'b1;
          rpt_raw = make_err(CNT_W'(ERR_MAX + 1), SIGN_NEG);
          cnt_nxt = CNT_W'(1);
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Optional dead zone on the reported magnitude.
  always_comb begin
    rpt_err = rpt_raw;
`ifdef PFD_DEADZONE_EN
    if (rpt_raw.mag <= ERR_W'(DEADZONE)) begin
      rpt_err.mag  = '0;
      rpt_err.sign = SIGN_POS;
    end
`endif
  end

  // Registered outputs; payload holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err.err_valid <= 1'b0;
      err.err_mag   <= '0;
      err.err_sign  <= SIGN_POS;
      err.err_sat   <= 1'b0;
    end else begin
      err.err_valid <= rpt;
      if (rpt) begin
        err.err_mag  <= rpt_err.mag;
        err.err_sign <= rpt_err.sign;
        err.err_sat  <= rpt_err.sat;
      end
    end
  end

endmodule
